// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, port width.
package dmem_pkg;

  localparam int DPORT = 32;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane decode: byte enables and fault flag from size/address, plus
// right-justify/zero-extend of the aligned 32-bit word into load data.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int AWIDTH = 10
) (
  input  logic [1:0]       size_i,
  input  logic [31:0]      addr_i,
  input  logic [DPORT-1:0] rword_i,
  output logic [3:0]       be_o,
  output logic             fault_o,
  output logic [DPORT-1:0] rdata_o
);

  logic [DPORT-1:0] shifted;

  always_comb begin
    be_o    = 4'b0000;
    fault_o = 1'b0;
    rdata_o = '0;
    shifted = rword_i >> {addr_i[1:0], 3'b000};
    case (size_i)
      SZ_WORD: begin
        be_o    = 4'b1111;
        fault_o = (addr_i[1:0] != 2'b00);
        rdata_o = shifted;
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << addr_i[1:0];
        fault_o = addr_i[0];
        rdata_o = {16'h0000, shifted[15:0]};
      end
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_i[1:0];
        rdata_o = {24'h000000, shifted[7:0]};
      end
      default: fault_o = 1'b1;
    endcase
    if ((addr_i >> AWIDTH) != 32'h0) fault_o = 1'b1;
    // A faulted access must neither write nor return data.
    if (fault_o) begin
      be_o    = 4'b0000;
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: one request at a time, response WAIT+1 cycles after accept, held until rsp_ready.
// DMEM_RESP_WAIT_EN compiles in the WAIT state and counter; otherwise WAIT is treated as 0.
module dmem_responder #(
  parameter int AWIDTH = 10,
  parameter int DPORT  = 32,
  parameter int WAIT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [1:0]       req_byte,
  input  logic [31:0]      req_addr,
  input  logic [DPORT-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DPORT-1:0] rsp_rdata,
  output logic             rsp_err
);
  import dmem_pkg::*;

  localparam int unsigned NBYTES = 1 << AWIDTH;

  state_t           state_q, state_d;
  logic             wr_q;
  logic [1:0]       size_q;
  logic [31:0]      addr_q;
  logic [DPORT-1:0] wdata_q;
  logic [DPORT-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       mem [NBYTES];

  logic             accept, access;
  logic             acc_wr;
  logic [1:0]       acc_size;
  logic [31:0]      acc_addr;
  logic [DPORT-1:0] acc_wdata, rword, wlane, acc_rdata;
  logic [3:0]       be;
  logic             fault;

  assign accept = req_valid && req_ready;
  assign access = (state_d == ST_RESP) && (state_q != ST_RESP);

  // With no wait states the access happens on the accept edge, so it uses the live request.
  always_comb begin
    acc_wr    = wr_q;
    acc_size  = size_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      acc_wr    = req_wr;
      acc_size  = req_byte;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) rword[8*k +: 8] = mem[{acc_addr[AWIDTH-1:2], 2'(k)}];
  end

  assign wlane = acc_wdata << {acc_addr[1:0], 3'b000};

  dmem_lane_align #(.AWIDTH(AWIDTH)) u_align (
    .size_i  (acc_size),
    .addr_i  (acc_addr),
    .rword_i (rword),
    .be_o    (be),
    .fault_o (fault),
    .rdata_o (acc_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst && access && acc_wr) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[{acc_addr[AWIDTH-1:2], 2'(k)}] <= wlane[8*k +: 8];
    end
  end

`ifdef DMEM_RESP_WAIT_EN
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && accept && WAIT > 0) cnt_d = 4'(WAIT - 1);
    else if (state_q == ST_WAIT && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (WAIT > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
`else
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      size_q  <= SZ_WORD;
      addr_q  <= 32'h0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= req_wr;
      size_q  <= req_byte;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (access) begin
      rsp_rdata_d = acc_wr ? '0 : acc_rdata;
      rsp_err_d   = fault;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, lane writes/reads, faults, response hold and mid-op reset.
module tb_dmem_responder;

`ifdef DMEM_RESP_WAIT_EN
  localparam int EFF_WAIT = 2;
`else
  localparam int EFF_WAIT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_byte = 2'b00;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.AWIDTH(10), .DPORT(32), .WAIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Present a request and return at the first falling edge after it is accepted.
  task automatic issue(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_byte = sz; req_addr = a; req_wdata = d;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Latency counted in cycles from the accept cycle; -1 means the response never came.
  task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got %h want 00000000", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
    wait_rsp(lat, rd, er);
    total++; if (lat !== EFF_WAIT + 1) begin bad++; $display("FAIL word_store_latency got %0d want %0d", lat, EFF_WAIT + 1); end
    total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL word_store_rsp got err=%b rdata=%h want err=0 rdata=00000000", er, rd); end
    finish_rsp();
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL word_store_idle got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
    issue(1'b0, 2'b00, 32'h10, 32'h0);
    wait_rsp(lat, rd, er);
    total++; if (lat !== EFF_WAIT + 1) begin bad++; $display("FAIL word_load_latency got %0d want %0d", lat, EFF_WAIT + 1); end
    total++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_load got err=%b rdata=%h want err=0 rdata=deadbeef", er, rd); end
    finish_rsp();
  endtask

  task automatic test_byte_half();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 2'b10, 32'h11, 32'hAAAAAA55);
    wait_rsp(lat, rd, er);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL byte_store_err got %b want 0", er); end
    finish_rsp();
    issue(1'b0, 2'b00, 32'h10, 32'h0);
    wait_rsp(lat, rd, er);
    total++; if (er !== 1'b0 || rd !== 32'hDEAD55EF) begin bad++; $display("FAIL byte_merge_word got err=%b rdata=%h want err=0 rdata=dead55ef", er, rd); end
    finish_rsp();
    issue(1'b0, 2'b01, 32'h12, 32'h0);
    wait_rsp(lat, rd, er);
    total++; if (er !== 1'b0 || rd !== 32'h0000DEAD) begin bad++; $display("FAIL half_load got err=%b rdata=%h want err=0 rdata=0000dead", er, rd); end
    finish_rsp();
    issue(1'b0, 2'b10, 32'h13, 32'h0);
    wait_rsp(lat, rd, er);
    total++; if (er !== 1'b0 || rd !== 32'h000000DE) begin bad++; $display("FAIL byte_load got err=%b rdata=%h want err=0 rdata=000000de", er, rd); end
    finish_rsp();
  endtask

  task automatic test_faults();
    logic        f_wr [5]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  f_sz [5]   = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b00};
    logic [31:0] f_addr [5] = '{32'h13, 32'h12, 32'h10, 32'h400, 32'h410};
    int lat; logic [31:0] rd; logic er;
    for (int i = 0; i < 5; i++) begin
      issue(f_wr[i], f_sz[i], f_addr[i], 32'h11223344);
      wait_rsp(lat, rd, er);
      total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL fault_%0d got err=%b rdata=%h want err=1 rdata=00000000", i, er, rd); end
      finish_rsp();
    end
    issue(1'b0, 2'b00, 32'h10, 32'h0);
    wait_rsp(lat, rd, er);
    total++; if (er !== 1'b0 || rd !== 32'hDEAD55EF) begin bad++; $display("FAIL fault_mem_unchanged got err=%b rdata=%h want err=0 rdata=dead55ef", er, rd); end
    finish_rsp();
  endtask

  task automatic test_hold();
    int lat; logic [31:0] rd; logic er;
    issue(1'b0, 2'b00, 32'h10, 32'h0);
    wait_rsp(lat, rd, er);
    for (int i = 0; i < 5; i++) begin
      req_valid = ~req_valid; req_wr = 1'b1; req_byte = 2'b00; req_addr = 32'h10; req_wdata = 32'h0;
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'hDEAD55EF || rsp_err !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle_%0d got valid=%b ready=%b rdata=%h err=%b want 1 0 dead55ef 0",
                 i, rsp_valid, req_ready, rsp_rdata, rsp_err);
      end
    end
    req_valid = 1'b0;
    finish_rsp();
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL hold_release got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
    issue(1'b0, 2'b00, 32'h10, 32'h0);
    wait_rsp(lat, rd, er);
    total++; if (rd !== 32'hDEAD55EF) begin bad++; $display("FAIL hold_no_second_accept got rdata=%h want dead55ef", rd); end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er; logic [31:0] exp_val;
    issue(1'b1, 2'b00, 32'h20, 32'hCAFEF00D);
    wait_rsp(lat, rd, er);
    finish_rsp();
    issue(1'b1, 2'b00, 32'h20, 32'h12345678);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL midreset_state got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
    repeat (4) @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_rsp got valid=%b want 0", rsp_valid); end
    exp_val = (EFF_WAIT == 0) ? 32'h12345678 : 32'hCAFEF00D;
    issue(1'b0, 2'b00, 32'h20, 32'h0);
    wait_rsp(lat, rd, er);
    total++; if (rd !== exp_val || er !== 1'b0) begin bad++; $display("FAIL midreset_mem got rdata=%h err=%b want %h 0", rd, er, exp_val); end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_faults();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
